mapper_savestate_ctrl: RTL and testbench
========================================

# mapper_savestate_ctrl

Savestate bus initiator for the mapper savestate register chain. It walks register indices 0..NUM_REGS-1 on the `SaveStateBus_*` interface. On save, it reads each mapper savestate register and streams the words out. On load, it accepts words from a stream, writes them into the registers, then pulses `SaveStateBus_load` so mappers copy the shadow values into live state. It sits between the mapper bank and the savestate memory DMA, and it holds the CPU paused for the whole operation.

## Interface
Parameters:
- `NUM_REGS`, 64: number of savestate indices walked (1..1024).
- `LOAD_HOLD`, 2: cycles `ss_load` stays high after the last write (≥1).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `save_start` in 1: one-cycle request to begin a save.
- `load_start` in 1: one-cycle request to begin a load.
- `busy` out 1: high from an accepted start until `done`.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky checksum mismatch flag; cleared by the next accepted start.
- `pause_req` out 1: CPU pause request.
- `pause_ack` in 1: CPU is halted.
- `sav_data` out 64, `sav_valid` out 1, `sav_ready` in 1: save output stream.
- `ld_data` in 64, `ld_valid` in 1, `ld_ready` out 1: load input stream.
- `ss_din` out 64, `ss_adr` out 10, `ss_wren` out 1, `ss_rst` out 1, `ss_load` out 1: drive the mappers' `SaveStateBus_Din/Adr/wren/rst/load`.
- `ss_dout` in 64: OR of all mappers' `SaveStateBus_Dout`.

## Operation
States: IDLE, WAIT_ACK, CLEAR, S_ADDR, S_CAP, S_PUSH, L_PULL, L_WRITE, L_LOAD, CHK, DONE.

- IDLE:
  - `save_start` → WAIT_ACK with mode=save.
  - Else `load_start` → WAIT_ACK with mode=load.
  - If both are asserted in the same cycle, save wins.
  - Starts outside IDLE are ignored.
- WAIT_ACK: `pause_req`=1 and stays 1 until DONE exits. Waits for `pause_ack`=1, then:
  - save → S_ADDR, idx=0.
  - load → CLEAR.
- CLEAR (load only): `ss_rst`=1 for exactly one cycle, so all registers take their defaults. Then → L_PULL, idx=0.
- S_ADDR: `ss_adr`=idx. → S_CAP.
- S_CAP: captures `ss_dout` into the output register. → S_PUSH.
- S_PUSH: `sav_valid`=1 with `sav_data` held stable until `sav_ready`.
  - On transfer: if idx==NUM_REGS-1 → CHK, else idx+1 → S_ADDR.
- L_PULL: `ld_ready`=1. On `ld_valid`, latches `ld_data` into `ss_din`. → L_WRITE.
- L_WRITE: `ss_adr`=idx, `ss_wren`=1 for one cycle.
  - If idx==NUM_REGS-1 → CHK, else idx+1 → L_PULL.
- CHK: see Configuration. Without the macro, passes straight through in one cycle:
  - save → DONE.
  - load → L_LOAD.
- L_LOAD: `ss_load`=1 for LOAD_HOLD cycles, with `ss_adr` and `ss_din` held. → DONE.
- DONE: `done`=1 for one cycle, then `busy`=0 and `pause_req`=0. → IDLE.

Rules:
- `idx` is 10 bits and `ss_adr`=idx[9:0]. No wrap occurs because the walk ends at NUM_REGS-1.
- `ss_wren`, `ss_rst` and `ss_load` are mutually exclusive and never overlap.

## Timing
- Reset value of every output is 0: `busy`, `done`, `error`, `pause_req`, `sav_valid`, `ld_ready`, `ss_*`, `sav_data`.
- Reset mid-operation aborts immediately to IDLE. A partially written load leaves mapper shadows stale, but `ss_load` was never asserted, so live mapper state is untouched.
- `busy` rises the cycle after an accepted start.
- `pause_ack` may take any number of cycles; deasserting it after it was sampled has no effect.
- Save throughput: 3 cycles per word with `sav_ready` held high.
- Load throughput: 2 cycles per word with `ld_valid` held high.
- Save latency with `pause_ack` already high: NUM_REGS·3 + 3 cycles from start to `done`.
- `sav_data` is registered and does not change while `sav_valid`=1 && !`sav_ready`.
- `ss_dout` is sampled exactly one cycle after `ss_adr` changes; mappers must present Dout combinationally from Adr.

## Configuration
- `SS_CHECKSUM_EN` defined:
  - A 64-bit running XOR of all register words is kept.
  - Save: CHK emits one extra stream word (the XOR) with the same valid/ready handshake, then → DONE. Total NUM_REGS+1 words.
  - Load: CHK pulls one extra word.
    - Match → L_LOAD.
    - Mismatch → `error`=1, L_LOAD is skipped, → DONE.
- Not defined: exactly NUM_REGS words in each direction, and `error` is constant 0.

## Test plan
- Reset while in S_PUSH → all outputs 0 the same cycle, state IDLE, and `done` never pulses.
- Save, NUM_REGS=4, `ss_dout`=0x11·(adr+1), `sav_ready`=1, `pause_ack` after 5 cycles:
  - `pause_req` high before any `ss_adr` activity.
  - Stream emits 0x11, 0x22, 0x33, 0x44 in order.
  - `done` pulses once.
- Save with `sav_ready` low for 7 cycles on word 2 → `sav_data` stable all 7 cycles, with no lost or duplicated word.
- Load, NUM_REGS=4, words A,B,C,D:
  - One `ss_rst` pulse first.
  - `ss_wren` at adr 0..3 with `ss_din` A..D.
  - Then `ss_load` high for exactly 2 cycles, no overlap.
- `save_start` and `load_start` asserted in the same cycle → save runs. A `load_start` issued while busy is ignored.
- With `SS_CHECKSUM_EN`:
  - Load of words 1,2,4,8 plus checksum 0x0F → `ss_load` pulses.
  - Same words with checksum 0x0E → `error`=1 and no `ss_load`.

Source files
------------

// File: rtl/mapper_savestate_ctrl.sv
// mapper_savestate_ctrl: savestate bus initiator for the mapper register chain.
// Save walks indices 0..NUM_REGS-1, reads each register over the savestate bus
// and streams the words out. Load clears the chain, writes streamed words into
// the register shadows, then pulses ss_load so mappers commit them.
// The CPU is held paused for the whole operation.
// Optional feature macro: SS_CHECKSUM_EN appends (save) or verifies (load) a
// 64-bit running-XOR checksum word after the register words.
//
// state    | meaning
// IDLE     | waiting for save_start / load_start
// WAIT_ACK | pause requested, waiting for pause_ack
// CLEAR    | one-cycle ss_rst so every register takes its default
// S_ADDR   | present idx on ss_adr
// S_CAP    | capture ss_dout into sav_data
// S_PUSH   | offer sav_data until sav_ready
// L_PULL   | accept one load word into ss_din
// L_WRITE  | one-cycle ss_wren at idx
// CHK      | checksum word out/in (single pass-through cycle without the macro)
// L_LOAD   | ss_load held for LOAD_HOLD cycles
// DONE     | one-cycle done pulse
module mapper_savestate_ctrl #(
  parameter int NUM_REGS  = 64,
  parameter int LOAD_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        save_start,
  input  logic        load_start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        pause_req,
  input  logic        pause_ack,
  output logic [63:0] sav_data,
  output logic        sav_valid,
  input  logic        sav_ready,
  input  logic [63:0] ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic [63:0] ss_din,
  output logic [9:0]  ss_adr,
  output logic        ss_wren,
  output logic        ss_rst,
  output logic        ss_load,
  input  logic [63:0] ss_dout
);

  localparam logic [9:0] IDX_LAST = 10'(NUM_REGS - 1);
  localparam int HOLD_W = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LOAD_HOLD - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_ACK, CLEAR, S_ADDR, S_CAP, S_PUSH,
    L_PULL, L_WRITE, L_LOAD, CHK, DONE
  } state_t;

  state_t            state, state_nxt;
  logic              mode_save;
  logic [9:0]        idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              idx_last;

`ifdef SS_CHECKSUM_EN
  logic [63:0] csum;
`endif

  assign idx_last = (idx == IDX_LAST);
  assign ss_adr   = idx;

  // State register; reset aborts any operation straight back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (save_start || load_start) state_nxt = WAIT_ACK;
      WAIT_ACK: if (pause_ack) state_nxt = mode_save ? S_ADDR : CLEAR;
      CLEAR:    state_nxt = L_PULL;
      S_ADDR:   state_nxt = S_CAP;
      S_CAP:    state_nxt = S_PUSH;
      S_PUSH:   if (sav_ready) state_nxt = idx_last ? CHK : S_ADDR;
      L_PULL:   if (ld_valid) state_nxt = L_WRITE;
      L_WRITE:  state_nxt = idx_last ? CHK : L_PULL;
`ifdef SS_CHECKSUM_EN
      CHK: begin
        if (mode_save) begin
          if (sav_ready) state_nxt = DONE;
        end else if (ld_valid) begin
          state_nxt = (ld_data == csum) ? L_LOAD : DONE;
        end
      end
`else
      CHK:      state_nxt = mode_save ? DONE : L_LOAD;
`endif
      L_LOAD:   if (hold_cnt == '0) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy      = (state != IDLE);
    pause_req = (state != IDLE);
    done      = (state == DONE);
    sav_valid = (state == S_PUSH);
    ld_ready  = (state == L_PULL);
    ss_wren   = (state == L_WRITE);
    ss_rst    = (state == CLEAR);
    ss_load   = (state == L_LOAD);
`ifdef SS_CHECKSUM_EN
    if (state == CHK) begin
      sav_valid = mode_save;
      ld_ready  = !mode_save;
    end
`endif
  end

  // Datapath: index walk, word capture, hold timer and checksum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_save <= 1'b0;
      idx       <= '0;
      hold_cnt  <= '0;
      sav_data  <= '0;
      ss_din    <= '0;
`ifdef SS_CHECKSUM_EN
      csum      <= '0;
      error     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (save_start || load_start) begin
            mode_save <= save_start;
            idx       <= '0;
`ifdef SS_CHECKSUM_EN
            csum      <= '0;
            error     <= 1'b0;
`endif
          end
        end
        S_CAP: begin
          sav_data <= ss_dout;
`ifdef SS_CHECKSUM_EN
          csum     <= csum ^ ss_dout;
`endif
        end
        S_PUSH: begin
          if (sav_ready) begin
            if (!idx_last) begin
              idx <= idx + 10'd1;
            end
`ifdef SS_CHECKSUM_EN
            else begin
              sav_data <= csum;
            end
`endif
          end
        end
        L_PULL: begin
          if (ld_valid) begin
            ss_din <= ld_data;
`ifdef SS_CHECKSUM_EN
            csum   <= csum ^ ld_data;
`endif
          end
        end
        L_WRITE: begin
          if (!idx_last) idx <= idx + 10'd1;
        end
        CHK: begin
          hold_cnt <= HOLD_INIT;
`ifdef SS_CHECKSUM_EN
          if (!mode_save && ld_valid && (ld_data != csum)) error <= 1'b1;
`endif
        end
        L_LOAD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifndef SS_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mapper_savestate_ctrl.sv
// Directed bench for mapper_savestate_ctrl with NUM_REGS=4, LOAD_HOLD=2.
// Mappers are modelled as ss_dout = 0x11*(ss_adr+1). Works with and without
// SS_CHECKSUM_EN defined.
module tb_mapper_savestate_ctrl;

  localparam int NR = 4;
`ifdef SS_CHECKSUM_EN
  localparam int NW = NR + 1;
`else
  localparam int NW = NR;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        save_start = 1'b0, load_start = 1'b0;
  logic        busy, done, error, pause_req;
  logic        pause_ack = 1'b0;
  logic [63:0] sav_data;
  logic        sav_valid;
  logic        sav_ready = 1'b0;
  logic [63:0] ld_data;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [63:0] ss_din;
  logic [9:0]  ss_adr;
  logic        ss_wren, ss_rst, ss_load;
  logic [63:0] ss_dout;

  logic [63:0] ld_words [16];
  logic [3:0]  ld_ptr = 4'd0;
  logic        adv = 1'b0;

  int errors = 0;
  int checks = 0;

  // monitor state
  logic [63:0] sav_log [64];
  logic [9:0]  wr_adr [64];
  logic [63:0] wr_din [64];
  int sav_n = 0, done_n = 0, rst_cnt = 0, rst_wr = 0, wr_n = 0;
  int load_n = 0, load_wr = 0, ldr_n = 0;
  logic hold_bad = 1'b0, ovl = 1'b0;
  logic [9:0]  last_adr = '0;
  logic [63:0] last_din = '0;

  logic [63:0] exp_sav [5] = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h44};

  assign ld_data = ld_words[ld_ptr];
  assign ss_dout = 64'(ss_adr + 10'd1) * 64'h11;

  mapper_savestate_ctrl #(.NUM_REGS(NR), .LOAD_HOLD(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .save_start(save_start), .load_start(load_start),
    .busy(busy), .done(done), .error(error),
    .pause_req(pause_req), .pause_ack(pause_ack),
    .sav_data(sav_data), .sav_valid(sav_valid), .sav_ready(sav_ready),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ss_din(ss_din), .ss_adr(ss_adr), .ss_wren(ss_wren), .ss_rst(ss_rst),
    .ss_load(ss_load), .ss_dout(ss_dout)
  );

  always #5 clk = ~clk;

  // bus / stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    adv = ld_valid && ld_ready;
    if (sav_valid && sav_ready) begin
      sav_log[sav_n[5:0]] = sav_data;
      sav_n++;
    end
    if (done) done_n++;
    if (ss_rst) begin
      rst_cnt++;
      rst_wr = wr_n;
    end
    if (ss_wren) begin
      wr_adr[wr_n[5:0]] = ss_adr;
      wr_din[wr_n[5:0]] = ss_din;
      last_adr = ss_adr;
      last_din = ss_din;
      wr_n++;
    end
    if (ss_load) begin
      load_n++;
      load_wr = wr_n;
      if (ss_adr != last_adr || ss_din != last_din) hold_bad = 1'b1;
    end
    if (int'(ss_wren) + int'(ss_rst) + int'(ss_load) > 1) ovl = 1'b1;
    if (ld_ready) ldr_n++;
  end

  // load-stream source advances after each accepted word
  always @(posedge clk) begin
    if (adv) begin
      #1 ld_ptr = ld_ptr + 4'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_flags"}, 64'({busy, done, error, pause_req, sav_valid, ld_ready,
                                ss_wren, ss_rst, ss_load}), 64'd0);
    check({tag, "_adr"}, 64'(ss_adr), 64'd0);
    check({tag, "_savdata"}, sav_data, 64'd0);
    check({tag, "_din"}, ss_din, 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 500) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 64'(done), 64'd1);
  endtask

  initial begin
    int s0, d0, w0, r0, l0, q0, n;
    logic early, stable_bad;
    logic [3:0] lb;

    for (int i = 0; i < 16; i++) ld_words[i] = '0;

    // reset
    #12;
    check_outs("reset");
    reset_n = 1'b1;
    tick();
    check_outs("post_reset");

    // save with pause_ack arriving 5 cycles late
    s0 = sav_n; d0 = done_n;
    sav_ready = 1'b1;
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    check("t1_busy_rise", 64'(busy), 64'd1);
    early = 1'b0;
    repeat (5) begin
      if (!pause_req || sav_valid || ss_adr != 10'd0 || ss_wren || ss_rst) early = 1'b1;
      tick();
    end
    check("t1_pause_first", 64'(early), 64'd0);
    pause_ack = 1'b1;
    wait_done("t1_done");
    tick();
    check("t1_word_cnt", 64'(sav_n - s0), 64'(NW));
    for (int i = 0; i < NW; i++) check("t1_word", sav_log[(s0 + i) % 64], exp_sav[i]);
    check("t1_done_cnt", 64'(done_n - d0), 64'd1);
    check("t1_idle", 64'({busy, pause_req}), 64'd0);
    check("t1_error", 64'(error), 64'd0);

    // save latency with pause_ack already high
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("t2_latency", 64'(n), 64'd15);
    tick();

    // sav_ready held low while word 2 is offered
    s0 = sav_n;
    sav_ready = 1'b0;
    stable_bad = 1'b0;
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    for (int w = 0; w < NW; w++) begin
      n = 0;
      while (!sav_valid && n < 50) begin
        tick();
        n++;
      end
      check("t3_valid_timeout", 64'(sav_valid), 64'd1);
      if (w == 1) begin
        if (sav_data != 64'h22) stable_bad = 1'b1;
        repeat (6) begin
          tick();
          if (!sav_valid || sav_data != 64'h22) stable_bad = 1'b1;
        end
      end
      sav_ready = 1'b1;
      tick();
      sav_ready = 1'b0;
    end
    wait_done("t3_done");
    tick();
    check("t3_stable", 64'(stable_bad), 64'd0);
    check("t3_word_cnt", 64'(sav_n - s0), 64'(NW));
    for (int i = 0; i < NW; i++) check("t3_word", sav_log[(s0 + i) % 64], exp_sav[i]);

    // load A..D
    lb = ld_ptr;
    ld_words[4'(lb + 4'd0)] = 64'hA000_0000_0000_000A;
    ld_words[4'(lb + 4'd1)] = 64'h0B00_0000_0000_00B0;
    ld_words[4'(lb + 4'd2)] = 64'h00C0_0000_0000_0C00;
    ld_words[4'(lb + 4'd3)] = 64'h000D_0000_0000_D000;
    ld_words[4'(lb + 4'd4)] = 64'hABCD_0000_0000_DCBA;
    w0 = wr_n; r0 = rst_cnt; l0 = load_n;
    ld_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wait_done("t4_done");
    ld_valid = 1'b0;
    tick();
    check("t4_rst_cnt", 64'(rst_cnt - r0), 64'd1);
    check("t4_rst_first", 64'(rst_wr), 64'(w0));
    check("t4_wren_cnt", 64'(wr_n - w0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4_wr_adr", 64'(wr_adr[(w0 + i) % 64]), 64'(i));
      check("t4_wr_din", wr_din[(w0 + i) % 64], ld_words[4'(lb + 4'(i))]);
    end
    check("t4_load_cycles", 64'(load_n - l0), 64'd2);
    check("t4_load_after_wr", 64'(load_wr), 64'(w0 + 4));
    check("t4_load_hold", 64'(hold_bad), 64'd0);
    check("t4_overlap", 64'(ovl), 64'd0);
    check("t4_words_taken", 64'(4'(ld_ptr - lb)), 64'(NW));
    check("t4_error", 64'(error), 64'd0);

    // simultaneous starts: save wins; load_start while busy ignored
    s0 = sav_n; d0 = done_n; r0 = rst_cnt; q0 = ldr_n; w0 = wr_n;
    sav_ready = 1'b1;
    save_start = 1'b1;
    load_start = 1'b1;
    tick();
    save_start = 1'b0;
    load_start = 1'b0;
    repeat (4) tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wait_done("t5_done");
    repeat (6) tick();
    check("t5_save_words", 64'(sav_n - s0), 64'(NW));
    check("t5_no_rst", 64'(rst_cnt - r0), 64'd0);
    check("t5_no_ldready", 64'(ldr_n - q0), 64'd0);
    check("t5_no_wren", 64'(wr_n - w0), 64'd0);
    check("t5_done_cnt", 64'(done_n - d0), 64'd1);
    check("t5_idle", 64'(busy), 64'd0);

    // reset while in S_PUSH
    sav_ready = 1'b0;
    s0 = sav_n;
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    n = 0;
    while (!sav_valid && n < 50) begin
      tick();
      n++;
    end
    check("t6_valid_timeout", 64'(sav_valid), 64'd1);
    d0 = done_n;
    #2 reset_n = 1'b0;
    #1;
    check_outs("t6_async");
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("t6_no_done", 64'(done_n - d0), 64'd0);
    check("t6_idle", 64'({busy, sav_valid, pause_req}), 64'd0);
    check("t6_no_words", 64'(sav_n - s0), 64'd0);

`ifdef SS_CHECKSUM_EN
    // load with matching checksum
    lb = ld_ptr;
    ld_words[4'(lb + 4'd0)] = 64'h1;
    ld_words[4'(lb + 4'd1)] = 64'h2;
    ld_words[4'(lb + 4'd2)] = 64'h4;
    ld_words[4'(lb + 4'd3)] = 64'h8;
    ld_words[4'(lb + 4'd4)] = 64'h0F;
    l0 = load_n;
    ld_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wait_done("t7_done");
    ld_valid = 1'b0;
    tick();
    check("t7_load_cycles", 64'(load_n - l0), 64'd2);
    check("t7_error", 64'(error), 64'd0);

    // load with bad checksum
    lb = ld_ptr;
    ld_words[4'(lb + 4'd0)] = 64'h1;
    ld_words[4'(lb + 4'd1)] = 64'h2;
    ld_words[4'(lb + 4'd2)] = 64'h4;
    ld_words[4'(lb + 4'd3)] = 64'h8;
    ld_words[4'(lb + 4'd4)] = 64'h0E;
    l0 = load_n; d0 = done_n;
    ld_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wait_done("t8_done");
    ld_valid = 1'b0;
    tick();
    check("t8_no_load", 64'(load_n - l0), 64'd0);
    check("t8_error", 64'(error), 64'd1);
    check("t8_done_cnt", 64'(done_n - d0), 64'd1);
    repeat (3) tick();
    check("t8_error_sticky", 64'(error), 64'd1);

    // next accepted start clears error
    sav_ready = 1'b1;
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    check("t9_error_clr", 64'(error), 64'd0);
    wait_done("t9_done");
    tick();
`else
    // plain load of 1,2,4,8: error stays 0, ss_load pulses
    lb = ld_ptr;
    ld_words[4'(lb + 4'd0)] = 64'h1;
    ld_words[4'(lb + 4'd1)] = 64'h2;
    ld_words[4'(lb + 4'd2)] = 64'h4;
    ld_words[4'(lb + 4'd3)] = 64'h8;
    l0 = load_n;
    ld_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wait_done("t7_done");
    ld_valid = 1'b0;
    tick();
    check("t7_load_cycles", 64'(load_n - l0), 64'd2);
    check("t7_error", 64'(error), 64'd0);
    check("t7_din_held", ss_din, 64'h8);
`endif

    check("final_overlap", 64'(ovl), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
